// File: rtl/fft_sample_buffer.sv
// fft_sample_buffer: ping-pong frame buffer that sits in front of the FFT core.
// Incoming samples fill one bank, optionally in bit-reversed address order.
// The other bank is owned by the reader through the FrameReady/FrameAck
// handshake and is read through a registered, one-cycle-latency port.
module fft_sample_buffer #(
   parameter int WIDTH  = 16,
   parameter int LOG2N  = 4,
   parameter int BITREV = 1
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [WIDTH-1:0] SampleIn,
   input  logic             SampleValid,
   input  logic [LOG2N-1:0] RdAddr,
   output logic [WIDTH-1:0] RdData,
   output logic             FrameReady,
   input  logic             FrameAck,
   output logic             Armed,
   output logic             Overrun,
   output logic [7:0]       FrameCount
);

   localparam int N = 1 << LOG2N;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [LOG2N-1:0] wp;
   logic [LOG2N-1:0] wr_addr;
   logic             wr_sel;
   logic [WIDTH-1:0] mem [0:2*N-1];

   logic             arm;
   logic             do_write;
   logic             last_write;
   logic             do_swap;
   logic             drop;
   logic             ack_clear;

   function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
      logic [LOG2N-1:0] r;
      for (int i = 0; i < LOG2N; i++) begin
         r[i] = a[LOG2N-1-i];
      end
      return r;
   endfunction

   assign wr_addr = (BITREV != 0) ? bitrev(wp) : wp;

   // Writer state register; reset abandons any partial or pending frame.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next writer state: a completed frame parks in HOLD only when the reader still owns its bank.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (Start) begin
               state_next = FILL;
            end
         end
         FILL: begin
            if (last_write && !do_swap) begin
               state_next = HOLD;
            end
         end
         HOLD: begin
            if (FrameAck) begin
               state_next = FILL;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Control strobes decoded from the state and the current-cycle inputs.
   always_comb begin
      arm        = 1'b0;
      do_write   = 1'b0;
      last_write = 1'b0;
      do_swap    = 1'b0;
      drop       = 1'b0;
      ack_clear  = 1'b0;
      case (state)
         IDLE: begin
            arm = Start;
         end
         FILL: begin
            do_write   = SampleValid;
            last_write = SampleValid && (wp == LOG2N'(N - 1));
            do_swap    = last_write && (!FrameReady || FrameAck);
         end
         HOLD: begin
            drop    = SampleValid;
            do_swap = FrameAck;
         end
         default: begin
            arm = 1'b0;
         end
      endcase
      ack_clear = FrameAck && FrameReady && !do_swap;
   end

   // Bank ownership, write pointer and handshake/status flags.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         Armed      <= 1'b0;
         FrameReady <= 1'b0;
         Overrun    <= 1'b0;
         FrameCount <= 8'd0;
         wp         <= '0;
         wr_sel     <= 1'b0;
      end else begin
         if (arm) begin
            Armed <= 1'b1;
         end
         if (drop) begin
            Overrun <= 1'b1;
         end
         if (do_swap) begin
            wr_sel     <= ~wr_sel;
            wp         <= '0;
            FrameReady <= 1'b1;
            FrameCount <= FrameCount + 8'd1;
         end else begin
            if (do_write && !last_write) begin
               wp <= wp + LOG2N'(1);
            end
            if (ack_clear) begin
               FrameReady <= 1'b0;
            end
         end
      end
   end

   // Sample storage: both banks in one array, bank select is the top address bit.
   always_ff @(posedge Clk) begin
      if (do_write) begin
         mem[{wr_sel, wr_addr}] <= SampleIn;
      end
   end

   // Registered read from the reader-owned bank.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         RdData <= '0;
      end else begin
         RdData <= mem[{~wr_sel, RdAddr}];
      end
   end

endmodule

// File: tb/tb_fft_sample_buffer.sv
// tb_fft_sample_buffer: drives a bit-reversed and a natural-order buffer from
// the same stimulus and checks status flags and read-back data.
module tb_fft_sample_buffer;

   logic        clk;
   logic        reset;
   logic        start;
   logic [15:0] sample_in;
   logic        sample_valid;
   logic [3:0]  rd_addr;
   logic        frame_ack;

   logic [15:0] rd_data_rev;
   logic        frame_ready_rev;
   logic        armed_rev;
   logic        overrun_rev;
   logic [7:0]  frame_count_rev;

   logic [15:0] rd_data_nat;
   logic        frame_ready_nat;
   logic        armed_nat;
   logic        overrun_nat;
   logic [7:0]  frame_count_nat;

   int total;
   int bad;

   typedef struct {
      logic [15:0] e_rev;
      logic [15:0] e_nat;
   } rd_exp_t;

   rd_exp_t sb[$];

   typedef struct {
      logic        start;
      logic        valid;
      logic        ack;
      logic [15:0] sample;
      logic        exp_armed;
      logic        exp_ready;
      logic [7:0]  exp_count;
      logic        exp_overrun;
   } vec_t;

   vec_t vecs[4];

   logic [15:0] rev_tab [16];

   fft_sample_buffer #(.WIDTH(16), .LOG2N(4), .BITREV(1)) dut_rev (
      .Clk        (clk),
      .Reset      (reset),
      .Start      (start),
      .SampleIn   (sample_in),
      .SampleValid(sample_valid),
      .RdAddr     (rd_addr),
      .RdData     (rd_data_rev),
      .FrameReady (frame_ready_rev),
      .FrameAck   (frame_ack),
      .Armed      (armed_rev),
      .Overrun    (overrun_rev),
      .FrameCount (frame_count_rev)
   );

   fft_sample_buffer #(.WIDTH(16), .LOG2N(4), .BITREV(0)) dut_nat (
      .Clk        (clk),
      .Reset      (reset),
      .Start      (start),
      .SampleIn   (sample_in),
      .SampleValid(sample_valid),
      .RdAddr     (rd_addr),
      .RdData     (rd_data_nat),
      .FrameReady (frame_ready_nat),
      .FrameAck   (frame_ack),
      .Armed      (armed_nat),
      .Overrun    (overrun_nat),
      .FrameCount (frame_count_nat)
   );

   // 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the sequence never completes.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got=%0d exp=%0d", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic st, input logic vld, input logic ack, input logic [15:0] smp);
      start        = st;
      sample_valid = vld;
      frame_ack    = ack;
      sample_in    = smp;
      tick();
      start        = 1'b0;
      sample_valid = 1'b0;
      frame_ack    = 1'b0;
   endtask

   task automatic checkStatus(input string tag, input logic a, input logic r, input logic [7:0] c, input logic o);
      checkOutput({tag, " armed"},   {31'd0, armed_rev},       {31'd0, a});
      checkOutput({tag, " ready"},   {31'd0, frame_ready_rev}, {31'd0, r});
      checkOutput({tag, " count"},   {24'd0, frame_count_rev}, {24'd0, c});
      checkOutput({tag, " overrun"}, {31'd0, overrun_rev},     {31'd0, o});
      checkOutput({tag, " nat ready"}, {31'd0, frame_ready_nat}, {31'd0, r});
   endtask

   task automatic readCheck(input string tag, input logic [3:0] addr, input logic [15:0] e_rev, input logic [15:0] e_nat);
      rd_exp_t item;
      rd_addr    = addr;
      item.e_rev = e_rev;
      item.e_nat = e_nat;
      sb.push_back(item);
      tick();
      item = sb.pop_front();
      checkOutput({tag, " rev rd"}, {16'd0, rd_data_rev}, {16'd0, item.e_rev});
      checkOutput({tag, " nat rd"}, {16'd0, rd_data_nat}, {16'd0, item.e_nat});
   endtask

   // Main sequence.
   initial begin
      total        = 0;
      bad          = 0;
      reset        = 1'b0;
      start        = 1'b0;
      sample_in    = '0;
      sample_valid = 1'b0;
      rd_addr      = '0;
      frame_ack    = 1'b0;

      rev_tab = '{16'd0, 16'd8, 16'd4, 16'd12, 16'd2, 16'd10, 16'd6, 16'd14,
                  16'd1, 16'd9, 16'd5, 16'd13, 16'd3, 16'd11, 16'd7, 16'd15};

      vecs[0] = '{start: 1'b0, valid: 1'b0, ack: 1'b1, sample: 16'd0,
                  exp_armed: 1'b0, exp_ready: 1'b0, exp_count: 8'd0, exp_overrun: 1'b0};
      vecs[1] = '{start: 1'b1, valid: 1'b0, ack: 1'b0, sample: 16'd0,
                  exp_armed: 1'b1, exp_ready: 1'b0, exp_count: 8'd0, exp_overrun: 1'b0};
      vecs[2] = '{start: 1'b0, valid: 1'b0, ack: 1'b1, sample: 16'd0,
                  exp_armed: 1'b1, exp_ready: 1'b0, exp_count: 8'd0, exp_overrun: 1'b0};
      vecs[3] = '{start: 1'b1, valid: 1'b0, ack: 1'b0, sample: 16'd0,
                  exp_armed: 1'b1, exp_ready: 1'b0, exp_count: 8'd0, exp_overrun: 1'b0};

      #3;
      checkStatus("in reset", 1'b0, 1'b0, 8'd0, 1'b0);
      checkOutput("in reset rddata", {16'd0, rd_data_rev}, 32'd0);
      tick();
      tick();
      reset = 1'b1;
      tick();

      // Samples without Start are ignored.
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 16'(500 + i));
      end
      checkStatus("unarmed", 1'b0, 1'b0, 8'd0, 1'b0);

      // Control vectors: stray acks and the arming pulse.
      for (int v = 0; v < 4; v++) begin
         applyStimulus(vecs[v].start, vecs[v].valid, vecs[v].ack, vecs[v].sample);
         checkStatus($sformatf("vec%0d", v), vecs[v].exp_armed, vecs[v].exp_ready,
                     vecs[v].exp_count, vecs[v].exp_overrun);
      end

      // First frame: values equal to sample index.
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 16'(i));
         checkOutput($sformatf("f1 ready after s%0d", i), {31'd0, frame_ready_rev}, (i == 15) ? 32'd1 : 32'd0);
      end
      checkStatus("f1 done", 1'b1, 1'b1, 8'd1, 1'b0);
      for (int k = 0; k < 16; k++) begin
         readCheck($sformatf("f1 a%0d", k), 4'(k), rev_tab[k], 16'(k));
      end

      // Second frame with no ack: writer fills then parks, extra samples overrun.
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 16'(100 + i));
      end
      checkStatus("f2 full", 1'b1, 1'b1, 8'd1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 16'd900);
      checkOutput("hold overrun", {31'd0, overrun_rev}, 32'd1);
      applyStimulus(1'b0, 1'b1, 1'b0, 16'd901);
      applyStimulus(1'b0, 1'b1, 1'b0, 16'd902);
      checkStatus("hold extra", 1'b1, 1'b1, 8'd1, 1'b1);
      readCheck("hold stable", 4'd1, 16'd8, 16'd1);
      applyStimulus(1'b0, 1'b0, 1'b1, 16'd0);
      checkStatus("hold ack", 1'b1, 1'b1, 8'd2, 1'b1);
      readCheck("f2 a0", 4'd0, 16'd100, 16'd100);
      readCheck("f2 a1", 4'd1, 16'd108, 16'd101);

      // Third frame with ack coincident with the last write: direct swap.
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b0, 1'b1, (i == 15), 16'(200 + i));
         if (i == 14) begin
            checkStatus("f3 s14", 1'b1, 1'b1, 8'd2, 1'b1);
         end
      end
      checkStatus("f3 swap", 1'b1, 1'b1, 8'd3, 1'b1);
      readCheck("f3 a0", 4'd0, 16'd200, 16'd200);
      readCheck("f3 a2", 4'd2, 16'd204, 16'd202);

      // Plain ack releases the frame; a second ack with nothing ready is ignored.
      applyStimulus(1'b0, 1'b0, 1'b1, 16'd0);
      checkStatus("release", 1'b1, 1'b0, 8'd3, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1, 16'd0);
      checkStatus("idle ack", 1'b1, 1'b0, 8'd3, 1'b1);

      // Reset in the middle of a frame.
      for (int i = 0; i < 7; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 16'(300 + i));
      end
      reset = 1'b0;
      #2;
      checkStatus("async reset", 1'b0, 1'b0, 8'd0, 1'b0);
      checkOutput("async reset rev rd", {16'd0, rd_data_rev}, 32'd0);
      checkOutput("async reset nat rd", {16'd0, rd_data_nat}, 32'd0);
      tick();
      reset = 1'b1;
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 16'd0);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 16'(400 + i));
         if (i == 14) begin
            checkStatus("post reset s14", 1'b1, 1'b0, 8'd0, 1'b0);
         end
      end
      checkStatus("post reset frame", 1'b1, 1'b1, 8'd1, 1'b0);
      readCheck("pr a0", 4'd0, 16'd400, 16'd400);
      readCheck("pr a15", 4'd15, 16'd415, 16'd415);
      readCheck("pr a3", 4'd3, 16'd412, 16'd403);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fft_sample_buffer.md
Name: fft_sample_buffer

Overview:
- Ping-pong frame buffer directly upstream of fft_sm.
- Collects a stream of input samples into N-entry frames, stored in bit-reversed address order.
- Hands each complete frame to the FFT core through a FrameReady/FrameAck handshake, with a synchronous-read port the core indexes.
- Capture is armed by the debounced Start pulse from the top level.

Parameters:
- WIDTH, 16, sample width in bits
- LOG2N, 4, log2 of frame length N (N = 16)
- BITREV, 1, 1 = write address is the bit-reversed sample index; 0 = natural order

Ports:
- Clk  in  1  system clock, all logic on rising edge
- Reset  in  1  asynchronous, active-low reset
- Start  in  1  single-cycle arm pulse (debounced button)
- SampleIn  in  WIDTH  input sample
- SampleValid  in  1  SampleIn valid this cycle
- RdAddr  in  LOG2N  read address from FFT core
- RdData  out  WIDTH  registered read data from the reader-owned bank
- FrameReady  out  1  a complete frame is owned by the reader
- FrameAck  in  1  single-cycle pulse; reader releases its bank
- Armed  out  1  capture enabled
- Overrun  out  1  sticky; a sample was dropped
- FrameCount  out  8  frames handed to the reader, wraps 255->0

Behaviour:
- Reset (Reset=0, async): Armed, FrameReady, Overrun, FrameCount, write pointer wp, wr_sel and RdData all go to 0. Writer state goes to IDLE. RAM contents are not reset.
- Reset asserted mid-frame: the partial frame and any pending frame are discarded.
- Storage: two banks of N x WIDTH.
  - wr_sel selects the writer bank; the reader bank is ~wr_sel.
- Writer FSM:
  - IDLE: samples are ignored. Start=1 sets Armed=1 and moves to FILL next cycle. Start in any other state is ignored.
  - FILL: on SampleValid, write SampleIn to bank[wr_sel] at address (BITREV ? bitrev(wp) : wp), then wp <= wp+1.
    - When the write at wp=N-1 occurs:
      - if FrameReady=0, or FrameAck=1 in the same cycle: swap (wr_sel toggles, wp <= 0, FrameReady <= 1, FrameCount++) and stay in FILL.
      - otherwise go to HOLD.
  - HOLD: writer bank is full and the reader is busy.
    - Any SampleValid sets Overrun=1; the sample is dropped.
    - On FrameAck: swap as above and return to FILL. FrameReady stays 1, because the new frame is immediately owned by the reader.
    - A SampleValid in the same cycle as that FrameAck is dropped and sets Overrun.
- Handshake:
  - FrameReady rises the cycle after the completing write.
  - FrameAck with FrameReady=1 and no concurrent swap: FrameReady <= 0 next cycle.
  - FrameAck with FrameReady=0 is ignored.
  - While FrameReady=1, the reader bank contents are stable.
- Read port: RdData <= bank[~wr_sel][RdAddr]. Latency is 1 cycle, and the reader may issue a new address every cycle.
  - With BITREV=1, RdAddr k returns sample index bitrev(k), which is DIT FFT input order.
  - Reads while FrameReady=0 return stale bank data (unspecified, no error).
- Overrun clears only on reset.
- Width rules:
  - wp is LOG2N bits and wraps N-1 -> 0 only via the swap.
  - FrameCount wraps modulo 256.

Test Plan:
- Reset held, then released; Start not pulsed; feed 20 samples -> Armed=0, FrameReady=0, FrameCount=0, Overrun=0.
- Pulse Start; feed samples 0..15 (value = index) on consecutive cycles -> FrameReady=1 on the cycle after sample 15; FrameCount=1. Read RdAddr 0..15 -> RdData, one cycle later, is 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15 (BITREV=1).
- With FrameReady=1 and no ack, feed 16 more samples, then 3 extra -> HOLD entered; Overrun=1. Pulse FrameAck -> swap; FrameReady stays 1; FrameCount=2; reading address 0 gives the first sample of the second frame.
- Arrange FrameAck in the same cycle as the 16th write of the next frame -> swap with no HOLD; Overrun unchanged; FrameReady stays 1; FrameCount increments once.
- Pulse Reset low after 7 samples of a frame -> all outputs 0 immediately (asynchronous). After Start, a fresh frame of 16 samples is required before FrameReady=1.
- BITREV=0 build: feed 0..15 -> RdAddr k returns k.
- Pulse FrameAck with FrameReady=0 -> no state change.
